bcd_stopwatch_ctrl: RTL
=======================

// Module: bcd_stopwatch_ctrl
// PURPOSE
//   Sequencing controller for the two-digit BCD counter datapath (tens/units packed in Q[7:4]/Q[3:0]).
//   Accepts start/stop/clear/lap command pulses, runs a prescaler that produces the count tick,
//   and owns the BCD increment and wrap logic. Presents either the live count or a frozen lap value.
//   It sits between the button/command logic and the 7-segment display decode.
// PARAMETERS
//   PRESCALE  10  clk cycles per count tick; legal range >= 2.
//   PS_W      8   prescaler width; must satisfy PRESCALE <= 2**PS_W.
// PORTS
//   clk       in   1  system clock, rising edge.
//   _rst      in   1  asynchronous, active-low reset.
//   start     in   1  command pulse: begin or resume counting.
//   stop      in   1  command pulse: pause counting.
//   clear     in   1  command pulse: return to IDLE and zero the count.
//   lap       in   1  command pulse: freeze or release the display (only with STOPWATCH_LAP_EN).
//   Q         out  8  displayed BCD value {tens, units}.
//   running   out  1  1 in RUN or HOLD.
//   tick      out  1  1-cycle pulse on every count increment.
//   overflow  out  1  sticky; set on wrap 99->00.
// BEHAVIOUR
//   - Reset (_rst=0, async): state=IDLE, count=8'h00, prescaler=0, lap_reg=8'h00.
//     Q=8'h00, running=0, tick=0, overflow=0. Reset takes effect immediately, including mid-RUN.
//   - FSM states: IDLE, RUN, PAUSE, HOLD (HOLD exists only with the macro).
//   - Commands are sampled on the rising clk edge. Priority: clear > stop > start > lap.
//   - State transitions:
//       * clear in any state -> IDLE; count=00, prescaler=0, overflow=0.
//       * IDLE: start -> RUN, prescaler=0.
//       * RUN: stop -> PAUSE; lap -> HOLD and lap_reg<=count.
//       * HOLD: lap -> RUN (display goes live); stop -> PAUSE (display goes live).
//       * PAUSE: start -> RUN; the prescaler keeps its value (no restart of the partial period).
//       * Any command not listed for the current state is ignored (start in RUN, lap in IDLE/PAUSE, stop in IDLE).
//   - Prescaler: advances only in RUN/HOLD, 0..PRESCALE-1. It returns to 0 after PRESCALE-1.
//   - tick is combinational: (state in RUN/HOLD) && prescaler==PRESCALE-1.
//     The count update is registered, so the new value is visible on the cycle after tick.
//   - A tick on the same cycle as stop is still applied; the stop takes effect for later cycles.
//   - BCD increment on tick:
//       * units<9: units+1.
//       * units==9: units=0, tens+1.
//       * count==8'h99: count becomes 8'h00 and overflow is set to 1.
//     Digits never leave the range 0..9.
//   - Q = lap_reg in HOLD, else count. Q is registered or driven straight from registers (no glitching decode).
//   - running is combinational from state. No output depends combinationally on the command inputs.
// CONFIGURATION
//   STOPWATCH_LAP_EN defined:
//     HOLD state, lap_reg and the lap input are all active, as described above.
//   STOPWATCH_LAP_EN undefined:
//     No HOLD state and no lap_reg. lap is ignored (port kept, unused). Q always equals count.
// TESTING (PRESCALE=10, 10 ns clk)
//   1. _rst low 20 ns, then start pulse at cycle 0
//      -> tick at cycle 9, Q=8'h01 at cycle 10; Q=8'h10 after 100 cycles; running=1.
//   2. Run 990 cycles to Q=8'h99, then 10 more
//      -> Q=8'h00, overflow=1 and stays 1. A clear pulse -> overflow=0, Q=8'h00, running=0.
//   3. stop at Q=8'h37 with prescaler=4
//      -> Q stays 8'h37 for 50 cycles, no tick.
//      A start pulse -> next tick 5 cycles later, Q=8'h38.
//   4. (macro defined) lap at Q=8'h12
//      -> Q holds 8'h12 for 30 cycles while count advances; second lap -> Q=8'h15 live.
//   5. clear+stop+start in the same cycle during RUN -> IDLE, Q=8'h00.
//      _rst low mid-RUN -> Q=8'h00, running=0 before the next clk edge.
//   6. (macro undefined) lap pulses in RUN -> no state change; Q continues to track count.

Source files
------------

// File: rtl/bcd_stopwatch_ctrl.sv
// Purpose : two-digit BCD stopwatch sequencer with prescaler, BCD increment/wrap and lap freeze.
// Latency : tick is combinational from state/prescaler; count and Q update on the edge after tick.
// Backpress: none; command pulses are sampled every rising edge, priority clear > stop > start > lap.
//
// Ports:
//   clk       rising-edge clock
//   _rst      asynchronous active-low reset
//   start     begin / resume counting
//   stop      pause counting
//   clear     return to IDLE and zero count, prescaler and overflow
//   lap       freeze / release the display (active only with STOPWATCH_LAP_EN)
//   Q         displayed BCD value {tens, units}, registered
//   running   1 in RUN or HOLD
//   tick      1-cycle pulse on each count increment
//   overflow  sticky flag, set on the 99 -> 00 wrap
//
// Build option: define STOPWATCH_LAP_EN to enable the HOLD state, lap register and lap input.
module bcd_stopwatch_ctrl #(
  parameter int PRESCALE = 10,
  parameter int PS_W     = 8
) (
  input  logic       clk,
  input  logic       _rst,
  input  logic       start,
  input  logic       stop,
  input  logic       clear,
  input  logic       lap,
  output logic [7:0] Q,
  output logic       running,
  output logic       tick,
  output logic       overflow
);

  typedef struct packed {
    logic [3:0] tens;
    logic [3:0] units;
  } bcd_t;

`ifdef STOPWATCH_LAP_EN
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2, HOLD = 2'd3} state_t;
`else
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, PAUSE = 2'd2} state_t;
`endif

  localparam logic [PS_W-1:0] PS_LAST = PS_W'(PRESCALE - 1);

  state_t          state, state_nx;
  bcd_t            count, count_nx, count_inc;
  logic [PS_W-1:0] ps, ps_nx;
  logic            ovf_nx;
  logic            wrap;
  logic            counting;
  logic [7:0]      q_nx;

`ifdef STOPWATCH_LAP_EN
  bcd_t lap_reg, lap_nx;
  assign counting = (state == RUN) || (state == HOLD);
`else
  logic unused_lap;
  assign unused_lap = lap;
  assign counting   = (state == RUN);
`endif

  assign running = counting;
  assign tick    = counting && (ps == PS_LAST);

  // BCD increment; units carry into tens, 99 wraps to 00.
  always_comb begin
    count_inc = count;
    wrap      = 1'b0;
    if (count.units == 4'd9) begin
      count_inc.units = 4'd0;
      if (count.tens == 4'd9) begin
        count_inc.tens = 4'd0;
        wrap           = 1'b1;
      end else begin
        count_inc.tens = count.tens + 4'd1;
      end
    end else begin
      count_inc.units = count.units + 4'd1;
    end
  end

  // Next-state logic. The tick-driven count update is computed before the
  // command decode so a stop landing on a tick cycle still keeps that increment.
  always_comb begin
    state_nx = state;
    count_nx = tick ? count_inc : count;
    ovf_nx   = overflow | (tick & wrap);
    ps_nx    = ps;
    if (counting) begin
      ps_nx = (ps == PS_LAST) ? '0 : ps + PS_W'(1);
    end
`ifdef STOPWATCH_LAP_EN
    lap_nx = lap_reg;
`endif

    if (clear) begin
      state_nx = IDLE;
      count_nx = '0;
      ps_nx    = '0;
      ovf_nx   = 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state_nx = RUN;
            ps_nx    = '0;
          end
        end
        RUN: begin
          if (stop) begin
            state_nx = PAUSE;
          end
`ifdef STOPWATCH_LAP_EN
          else if (lap) begin
            state_nx = HOLD;
            lap_nx   = count;
          end
`endif
        end
        // Resume keeps the prescaler so the partial period is not restarted.
        PAUSE: begin
          if (start) begin
            state_nx = RUN;
          end
        end
`ifdef STOPWATCH_LAP_EN
        HOLD: begin
          if (stop) begin
            state_nx = PAUSE;
          end else if (lap) begin
            state_nx = RUN;
          end
        end
`endif
        default: state_nx = IDLE;
      endcase
    end

`ifdef STOPWATCH_LAP_EN
    q_nx = (state_nx == HOLD) ? lap_nx : count_nx;
`else
    q_nx = count_nx;
`endif
  end

  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      state    <= IDLE;
      count    <= '0;
      ps       <= '0;
      overflow <= 1'b0;
      Q        <= 8'h00;
`ifdef STOPWATCH_LAP_EN
      lap_reg  <= '0;
`endif
    end else begin
      state    <= state_nx;
      count    <= count_nx;
      ps       <= ps_nx;
      overflow <= ovf_nx;
      Q        <= q_nx;
`ifdef STOPWATCH_LAP_EN
      lap_reg  <= lap_nx;
`endif
    end
  end

endmodule
